// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, redirect flushes and a
// RUN/HALT/DRAIN syscall halt FSM. Define HAZARD_STATS_EN to build the counters.
module hazard_ctrl #(
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_ld,
  input  logic                ex_RegWrite,
  input  logic [4:0]          ex_write,
  input  logic                ex_redirect,
  input  logic                ex_Syscall,
  input  logic                halt_cond,
  input  logic                resume,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ifid_zero,
  output logic                idex_en,
  output logic                idex_zero,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic                halted,
  output logic [CNT_BITS-1:0] bubble_cnt,
  output logic [CNT_BITS-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, HALT, DRAIN} state_t;

  state_t state, state_nxt;
  logic   luh;
  logic   halt_ev;

  assign luh = ex_ld & ex_RegWrite & (ex_write != 5'd0) &
               ((id_uses_rs & (id_rs == ex_write)) |
                (id_uses_rt & (id_rt == ex_write)));
  assign halt_ev = ex_Syscall & halt_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_zero = 1'b0;
    idex_en   = 1'b1;
    idex_zero = 1'b0;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    halted    = 1'b0;
    if (!rst_n) begin
      // Outputs are combinational, so reset must force them directly.
      state_nxt = RUN;
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      ifid_zero = 1'b1;
      idex_en   = 1'b0;
      idex_zero = 1'b1;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_ev) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            state_nxt = HALT;
          end else if (ex_redirect) begin
            // ID holds a wrong-path instruction, so flushing wins over a bubble.
            ifid_zero = 1'b1;
            idex_zero = 1'b1;
          end else if (luh) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_zero = 1'b1;
          end
        end
        HALT: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_en = 1'b0;
          halted  = 1'b1;
          if (resume) state_nxt = DRAIN;
        end
        DRAIN: begin
          // Squash the syscall still sitting in ID_EX so it cannot re-halt.
          idex_zero = 1'b1;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic bubble_act;
  logic flush_act;

  assign bubble_act = (state == RUN) & ~halt_ev & ~ex_redirect & luh;
  assign flush_act  = (state == RUN) & ~halt_ev & ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (bubble_act) bubble_cnt <= bubble_cnt + CNT_BITS'(1);
      if (flush_act)  flush_cnt  <= flush_cnt + CNT_BITS'(1);
    end
  end
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule
